decode_sched: RTL and testbench

- Job-level sequencer for the LZS decode controller.
- Accepts decode job descriptors (id, expected output length) over a valid/ready handshake.
- Soft-clears the decoder, enables it, counts bytes it emits, and detects end-of-stream or stall timeout.
- Returns one status record per job over a second valid/ready handshake.
- Sits between the host/DMA command path and the decoder's ce / out_valid / out_done pins.

---
 rtl/decode_sched.sv | 167 ++++++++++++++++
 tb/tb_decode_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sched.sv
// Job-level sequencer for the LZS decoder: clear, enable, count bytes, report one status per job.
// Optional abort input is enabled by defining DECODE_SCHED_ABORT_EN.
module decode_sched #(
  parameter int          LEN_W     = 16,
  parameter int          ID_W      = 4,
  parameter int          TO_W      = 16,
  parameter int unsigned TIMEOUT   = 16'hFFFF,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [ID_W-1:0]  job_id,
  input  logic [LEN_W-1:0] job_len,
  output logic             dec_srst,
  output logic             dec_ce,
  input  logic             dec_out_valid,
  input  logic             dec_out_done,
`ifdef DECODE_SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic             sts_valid,
  input  logic             sts_ready,
  output logic [ID_W-1:0]  sts_id,
  output logic [LEN_W-1:0] sts_count,
  output logic [2:0]       sts_code,
  output logic             busy
);

  localparam int DR_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  // Idle count that, once reached with no byte this cycle, completes TIMEOUT silent cycles
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT - 1);

  localparam logic [2:0] CODE_OK    = 3'd0;
  localparam logic [2:0] CODE_SHORT = 3'd1;
  localparam logic [2:0] CODE_LONG  = 3'd2;
  localparam logic [2:0] CODE_TOUT  = 3'd3;
  localparam logic [2:0] CODE_ABORT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_ABRT,
    S_REPORT
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] cnt_nxt;
  logic [LEN_W-1:0] len_q;
  logic [ID_W-1:0]  id_q;
  logic [TO_W-1:0]  idle_cnt;
  logic [DR_W-1:0]  drain_cnt;
  logic [2:0]       code_q;
  logic             abort_i;

`ifdef DECODE_SCHED_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  always_comb begin
    cnt_nxt = count;
    if (dec_out_valid && (count != '1))
      cnt_nxt = count + LEN_W'(1);
  end

  function automatic logic [2:0] len_code(input logic [LEN_W-1:0] c, input logic [LEN_W-1:0] l);
    if (c == l)     return CODE_OK;
    else if (c < l) return CODE_SHORT;
    else            return CODE_LONG;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      len_q     <= '0;
      id_q      <= '0;
      idle_cnt  <= '0;
      drain_cnt <= '0;
      code_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            id_q  <= job_id;
            len_q <= job_len;
            count <= '0;
            state <= S_CLR;
          end
        end
        S_CLR: begin
          idle_cnt <= '0;
          if (abort_i) begin
            code_q <= CODE_ABORT;
            state  <= S_ABRT;
          end else begin
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            code_q <= CODE_ABORT;
            state  <= S_ABRT;
          end else begin
            count <= cnt_nxt;
            if (dec_out_valid)
              idle_cnt <= '0;
            else if (idle_cnt != '1)
              idle_cnt <= idle_cnt + TO_W'(1);
            // End-of-stream takes priority over a coincident timeout
            if (dec_out_done) begin
              if (DRAIN_CYC == 0) begin
                code_q <= len_code(cnt_nxt, len_q);
                state  <= S_REPORT;
              end else begin
                drain_cnt <= DR_W'(DRAIN_CYC);
                state     <= S_DRAIN;
              end
            end else if (!dec_out_valid && (idle_cnt == TO_LIM)) begin
              code_q <= CODE_TOUT;
              state  <= S_REPORT;
            end
          end
        end
        S_DRAIN: begin
          if (abort_i) begin
            code_q <= CODE_ABORT;
            state  <= S_ABRT;
          end else begin
            count <= cnt_nxt;
            if (drain_cnt <= DR_W'(1)) begin
              code_q <= len_code(cnt_nxt, len_q);
              state  <= S_REPORT;
            end else begin
              drain_cnt <= drain_cnt - DR_W'(1);
            end
          end
        end
        S_ABRT: begin
          state <= S_REPORT;
        end
        S_REPORT: begin
          if (sts_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs come straight from registers; no input reaches them combinationally
  assign job_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dec_srst  = (state == S_CLR) || (state == S_ABRT);
  assign dec_ce    = (state == S_RUN) || (state == S_DRAIN);
  assign sts_valid = (state == S_REPORT);
  assign sts_id    = id_q;
  assign sts_count = count;
  assign sts_code  = code_q;

endmodule

// File: tb/tb_decode_sched.sv
// Directed bench for decode_sched with a job-level expectation model and per-cycle compare.
module tb_decode_sched;

  localparam int LEN_W     = 16;
  localparam int ID_W      = 4;
  localparam int TOUT      = 16;
  localparam int DRAIN     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [ID_W-1:0]  job_id;
  logic [LEN_W-1:0] job_len;
  logic             dec_srst;
  logic             dec_ce;
  logic             dec_out_valid;
  logic             dec_out_done;
`ifdef DECODE_SCHED_ABORT_EN
  logic             abort;
`endif
  logic             sts_valid;
  logic             sts_ready;
  logic [ID_W-1:0]  sts_id;
  logic [LEN_W-1:0] sts_count;
  logic [2:0]       sts_code;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  logic chk_en = 1'b0;
  logic e_ready, e_busy, e_ce, e_srst, e_vld;
  int   e_id, e_cnt, e_code;

  always #5 clk = ~clk;

  decode_sched #(.LEN_W(LEN_W), .ID_W(ID_W), .TO_W(16), .TIMEOUT(TOUT), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk),
    .rst(rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_id(job_id),
    .job_len(job_len),
    .dec_srst(dec_srst),
    .dec_ce(dec_ce),
    .dec_out_valid(dec_out_valid),
    .dec_out_done(dec_out_done),
`ifdef DECODE_SCHED_ABORT_EN
    .abort(abort),
`endif
    .sts_valid(sts_valid),
    .sts_ready(sts_ready),
    .sts_id(sts_id),
    .sts_count(sts_count),
    .sts_code(sts_code),
    .busy(busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("job_ready", job_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("dec_ce", dec_ce, e_ce);
      chk("dec_srst", dec_srst, e_srst);
      chk("sts_valid", sts_valid, e_vld);
      if (e_vld) begin
        chk("sts_id", sts_id, e_id);
        chk("sts_count", sts_count, e_cnt);
        chk("sts_code", sts_code, e_code);
      end
    end
  end

  function automatic logic [127:0] mk(input int lo, input int hi);
    logic [127:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Job outcome from the decoder activity seen relative to the first enabled cycle.
  task automatic predict(input logic [127:0] pat, input int done_at, input int abort_at, input int len,
                         output int rep_at, output int ce_end, output int cnt, output int code);
    int quiet = 0;
    bit fin = 0;
    cnt = 0; rep_at = 0; ce_end = 0; code = -1;
    for (int i = 0; i < 100 && !fin; i++) begin
      if (i == abort_at) begin
        rep_at = i + 2; ce_end = i + 1; code = 4; fin = 1;
      end else begin
        if (pat[i]) begin cnt++; quiet = 0; end
        else quiet++;
        if (i == done_at) begin
          for (int d = 1; d <= DRAIN; d++) if (pat[i+d]) cnt++;
          rep_at = i + 1 + DRAIN; ce_end = rep_at;
          code = (cnt == len) ? 0 : (cnt < len) ? 1 : 2;
          fin = 1;
        end else if (quiet == TOUT) begin
          rep_at = i + 1; ce_end = rep_at; code = 3; fin = 1;
        end
      end
    end
  endtask

  task automatic set_idle_exp();
    e_ready = 1; e_busy = 0; e_ce = 0; e_srst = 0; e_vld = 0;
  endtask

  task automatic drive_idle();
    job_valid = 0; job_id = '0; job_len = '0; dec_out_valid = 0; dec_out_done = 0; sts_ready = 0;
`ifdef DECODE_SCHED_ABORT_EN
    abort = 0;
`endif
  endtask

  task automatic run_job(input int id, input int len, input logic [127:0] pat, input int done_at,
                         input int abort_at, input int hold, input int l_rep, input int l_cnt, input int l_code);
    int rep_at, ce_end, cnt, code;
    predict(pat, done_at, abort_at, len, rep_at, ce_end, cnt, code);
    chk("model_report_cycle", rep_at, l_rep);
    chk("model_count", cnt, l_cnt);
    chk("model_code", code, l_code);
    @(posedge clk); #1;
    job_valid = 1; job_id = ID_W'(id); job_len = LEN_W'(len); dec_out_valid = 1;
    set_idle_exp();
    @(posedge clk); #1;
    job_valid = 0; job_id = '0; dec_out_valid = 1;
    e_ready = 0; e_busy = 1; e_ce = 0; e_srst = 1; e_vld = 0;
    e_id = id; e_cnt = cnt; e_code = code;
    for (int i = 0; i <= rep_at + hold; i++) begin
      @(posedge clk); #1;
      dec_out_valid = pat[i];
      dec_out_done  = (i == done_at);
`ifdef DECODE_SCHED_ABORT_EN
      abort = (i == abort_at);
`endif
      sts_ready = (i >= rep_at + hold);
      job_valid = (i >= rep_at);
      job_id    = 4'hF;
      e_ready = 0; e_busy = 1;
      e_ce   = (i < ce_end);
      e_srst = (abort_at >= 0) && (i == abort_at + 1);
      e_vld  = (i >= rep_at);
      if (i == rep_at) begin
        @(negedge clk); #1;
        chk("lit_sts_count", sts_count, l_cnt);
        chk("lit_sts_code", sts_code, l_code);
        chk("lit_sts_id", sts_id, id);
      end
    end
    @(posedge clk); #1;
    drive_idle();
    set_idle_exp();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    set_idle_exp();
    #3;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dec_ce", dec_ce, 0);
    chk("rst_dec_srst", dec_srst, 0);
    chk("rst_sts_valid", sts_valid, 0);
    chk("rst_sts_count", sts_count, 0);
    chk("rst_sts_code", sts_code, 0);
    chk("rst_sts_id", sts_id, 0);
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    //      id len pattern              done abort hold rep cnt code
    run_job(3, 10, mk(0, 9),              9,  -1,   0, 12, 10, 0);
    run_job(5, 10, mk(0, 7) | mk(9, 12),  8,  -1,   0, 11, 10, 0);
    run_job(1,  5, mk(0, 6),              6,  -1,   0,  9,  7, 2);
    run_job(2,  5, mk(0, 2),              4,  -1,   0,  7,  3, 1);
    run_job(7,  8, mk(0, 3),             -1,  -1,   0, 20,  4, 3);
    run_job(9,  4, mk(0, 3),             19,  -1,   0, 22,  4, 0);
    run_job(10, 2, mk(0, 1),              1,  -1,  20,  4,  2, 0);
`ifdef DECODE_SCHED_ABORT_EN
    run_job(6,  9, mk(0, 5),             10,   7,   0,  9,  6, 4);
`endif

    // Reset in the middle of a running job
    chk_en = 0;
    @(posedge clk); #1;
    job_valid = 1; job_id = 4'h8; job_len = 16'd3;
    @(posedge clk); #1;
    job_valid = 0; dec_out_valid = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_run_ce", dec_ce, 1);
    #1 rst = 1;
    #1;
    chk("mid_rst_job_ready", job_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dec_ce", dec_ce, 0);
    chk("mid_rst_sts_valid", sts_valid, 0);
    chk("mid_rst_sts_count", sts_count, 0);
    chk("mid_rst_sts_id", sts_id, 0);
    drive_idle();
    @(posedge clk); #1;
    rst = 0;
    set_idle_exp();
    chk_en = 1;
    repeat (5) @(posedge clk);
    #1;
    run_job(4,  1, mk(0, 0),              0,  -1,   0,  3,  1, 0);
    repeat (2) @(posedge clk);
    #1 chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
